mem_bist_initiator: RTL and testbench
=====================================

Name: mem_bist_initiator

Overview:
- Initiator for the single-port memory valid/ready interface; it drives the memory's requests.
- On `start`, writes a deterministic pattern to every address, then reads every address back and compares.
- Reports pass/fail, error count, first failing address and a ready-timeout flag.
- Sits between test/control logic and one single-port memory instance.

Parameters:
- WIDTH, 8: memory data width.
- DEPTH, 16: number of words; addresses 0..DEPTH-1.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- SEED, 8'hA5: pattern seed, zero-extended or truncated to WIDTH.
- TIMEOUT, 64: maximum consecutive cycles `valid` may stay high without `ready` before abort.

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run a test; ignored unless idle.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  1 = no mismatches and no timeout; valid from `done` until next `start`.
- timeout  out  1  sticky abort flag, cleared on next `start`.
- err_count  out  ADDR_WIDTH+1  number of read mismatches, saturating at DEPTH.
- first_fail_addr  out  ADDR_WIDTH  address of first mismatch; 0 if none.
- valid  out  1  memory request valid.
- wr_rd_en  out  1  1 = write, 0 = read.
- addr  out  ADDR_WIDTH  request address.
- wdata  out  WIDTH  write data.
- rdata  in  WIDTH  read data, valid in the cycle `ready` is high on a read.
- ready  in  1  memory accepts or completes the current request at this clock edge.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, FSM in IDLE, counters 0; takes effect immediately, including mid-test.
- Pattern: pat(a) = SEED ^ a, with a zero-extended to WIDTH.
- Handshake:
  - A transfer completes at a rising edge where valid=1 and ready=1.
  - addr, wr_rd_en and wdata stay stable while valid=1 and ready=0.
  - valid never drops before completion, except on timeout or reset.
  - On a read, rdata is sampled at the completing edge.
- Back-to-back: the next request is presented in the cycle after completion with valid kept high; there are no idle bubbles between transfers.
- FSM states: IDLE, WRITE, READ, FINISH.
  - IDLE: start=1 at an edge → WRITE with addr=0, wr_rd_en=1, wdata=pat(0), valid=1, busy=1. The edge also clears err_count, first_fail_addr, timeout and pass.
  - WRITE: on completion at addr<DEPTH-1, addr++ and wdata=pat(addr+1). On completion at DEPTH-1 → READ with addr=0, wr_rd_en=0, wdata=0.
  - READ: on completion, compare rdata with pat(addr).
    - On mismatch: err_count++ (saturating); first_fail_addr is captured only when err_count was 0.
    - At addr<DEPTH-1, addr++. At DEPTH-1 → FINISH with valid=0.
  - FINISH: one cycle with done=1, busy=0, pass=(err_count==0 && !timeout) → IDLE.
- Timeout:
  - A wait counter increments each cycle with valid=1 and ready=0, and clears on completion.
  - When it reaches TIMEOUT: valid=0, timeout=1 → FINISH (pass=0).
  - Completed transfers are not retried.
- start while busy or in FINISH: ignored.
- Latency with ready tied high:
  - start at edge E0; writes complete at E1..E_DEPTH; reads complete at E_DEPTH+1..E_2·DEPTH.
  - done is high between E_2·DEPTH and E_2·DEPTH+1.
- A mismatch on the last address still updates err_count before done.

Test Plan:
- Ideal memory, ready=1 always, DEPTH=16, SEED=A5:
  - addr 3 is written with A6.
  - done fires 32 cycles after start; pass=1, err_count=0, timeout=0.
- Memory asserts ready 2 cycles after each valid:
  - Request signals hold stable while waiting.
  - done comes at about 96 cycles; pass=1.
- Memory corrupts reads at addr 5 and 9:
  - err_count=2, first_fail_addr=5, pass=0.
- ready stuck low, TIMEOUT=64:
  - valid drops after 64 cycles at addr 0, write.
  - timeout=1, done pulse, pass=0.
- Assert reset low mid-write at addr 7:
  - valid, busy, done and pass go 0 immediately.
  - After release, a new start runs cleanly and gives pass=1.
- start pulsed during READ:
  - Ignored, single done pulse.
  - A second start after done reruns the test and clears the prior err_count.

Source files
------------

// File: rtl/mem_bist_initiator.sv
// mem_bist_initiator: write-then-read-back self test for one single-port memory.
//   clk, reset (async, active-low), start   - control inputs
//   busy, done, pass, timeout               - test status
//   err_count, first_fail_addr              - mismatch statistics
//   valid, wr_rd_en, addr, wdata            - memory request (registered)
//   rdata, ready                            - memory response
// Pattern written to address a is SEED ^ a. DEPTH must be at least 2.
module mem_bist_initiator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned SEED       = 32'h0000_00A5,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  valid,
    output logic                  wr_rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready
);

    localparam int unsigned ERR_W  = ADDR_WIDTH + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ERR_W-1:0]      ERR_MAX   = ERR_W'(DEPTH);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        FINISH
    } state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;

    logic               xfer_c;
    logic               last_c;
    logic               mismatch_c;
    logic               expire_c;
    logic [ERR_W-1:0]   err_next_c;

    // Expected word for an address.
    function automatic logic [WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
        return WIDTH'(SEED) ^ WIDTH'(a);
    endfunction

    // Handshake qualifiers and next error count for the current cycle.
    always_comb begin
        xfer_c     = 1'b0;
        last_c     = 1'b0;
        mismatch_c = 1'b0;
        expire_c   = 1'b0;
        err_next_c = err_count;
        xfer_c     = valid && ready;
        last_c     = (addr == LAST_ADDR);
        mismatch_c = xfer_c && !wr_rd_en && (rdata != pat(addr));
        expire_c   = valid && !ready && (wait_cnt == WAIT_LAST);
        if (mismatch_c && (err_count != ERR_MAX)) begin
            err_next_c = err_count + ERR_W'(1);
        end
    end

    // Test sequencer: state, request and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            valid           <= 1'b0;
            wr_rd_en        <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= WRITE;
                        wait_cnt        <= '0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        timeout         <= 1'b0;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                        valid           <= 1'b1;
                        wr_rd_en        <= 1'b1;
                        addr            <= '0;
                        wdata           <= pat('0);
                    end
                end

                WRITE, READ: begin
                    if (xfer_c) begin
                        wait_cnt <= '0;
                        if (state == READ) begin
                            err_count <= err_next_c;
                            // Only the first mismatch of a run is recorded.
                            if (mismatch_c && (err_count == '0)) begin
                                first_fail_addr <= addr;
                            end
                        end
                        if (!last_c) begin
                            addr <= addr + ADDR_WIDTH'(1);
                            if (state == WRITE) begin
                                wdata <= pat(addr + ADDR_WIDTH'(1));
                            end
                        end else if (state == WRITE) begin
                            state    <= READ;
                            addr     <= '0;
                            wr_rd_en <= 1'b0;
                            wdata    <= '0;
                        end else begin
                            // Last read: pass uses the count including this compare.
                            state <= FINISH;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next_c == '0) && !timeout;
                        end
                    end else if (expire_c) begin
                        // Memory never answered: abandon the request and report.
                        state    <= FINISH;
                        wait_cnt <= '0;
                        valid    <= 1'b0;
                        timeout  <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= 1'b0;
                    end else if (valid) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// tb_mem_bist_initiator: drives mem_bist_initiator against a behavioural memory
// with selectable ready behaviour and read corruption, and checks results
// against expectations computed from the pattern rule.
module tb_mem_bist_initiator;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned TIMEOUT = 64;
    localparam logic [7:0]  SEED    = 8'hA5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic             tmo;
    logic [AW:0]      err_count;
    logic [AW-1:0]    first_fail_addr;
    logic             valid;
    logic             wr_rd_en;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata = '0;
    logic             ready = 1'b1;

    int tests = 0;
    int fails = 0;

    // Memory model state (written only by the responder process).
    logic [WIDTH-1:0] mem [DEPTH];
    logic [31:0]      obs_q [$];
    int               wcnt = 0;
    int               vh_total = 0;
    int               hold_bad = 0;
    logic [31:0]      held = '0;
    logic [31:0]      last_req = '0;
    logic [WIDTH-1:0] w3 = '0;

    // Stimulus controls (written only by the test process).
    int               mode = 0;
    int               lat = 2;
    logic [WIDTH-1:0] cmask [DEPTH];

    mem_bist_initiator #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .SEED      (32'h0000_00A5),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (tmo),
        .err_count      (err_count),
        .first_fail_addr(first_fail_addr),
        .valid          (valid),
        .wr_rd_en       (wr_rd_en),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .ready          (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: decides ready for the coming edge and logs completions.
    // mode 0: ready tied high, 1: ready after lat waiting cycles, 2: stuck low, 3: random.
    always @(negedge clk) begin
        logic [31:0] cur;
        if (valid) begin
            vh_total++;
            cur = 32'({wr_rd_en, addr, wdata});
            last_req = cur;
            if (wcnt > 0 && cur != held) hold_bad++;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (wcnt >= lat);
                2:       ready = 1'b0;
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            rdata = wr_rd_en ? WIDTH'($urandom()) : (mem[addr] ^ cmask[addr]);
            if (ready) begin
                obs_q.push_back(cur);
                if (wr_rd_en) begin
                    mem[addr] = wdata;
                    if (addr == AW'(3)) w3 = wdata;
                end
                wcnt = 0;
            end else begin
                wcnt++;
                held = cur;
            end
        end else begin
            wcnt = 0;
            ready = (mode == 0);
            if (!busy) begin
                foreach (mem[i]) mem[i] = WIDTH'($urandom());
            end
        end
    end

    // One complete test run; expectations come from the corrupted-address set.
    task automatic run_test(input int m, input logic [DEPTH-1:0] cset, input int poke);
        int cyc;
        int base_x;
        int base_vh;
        int base_hb;
        int exp_err;
        int exp_ffa;
        int exp_lat;
        int n;
        logic exp_pass;
        logic poked;
        logic [7:0] p;
        logic [31:0] e;

        mode = m;
        exp_err = 0;
        exp_ffa = 0;
        for (int a = 0; a < DEPTH; a++) begin
            cmask[a] = cset[a] ? WIDTH'($urandom_range(1, 255)) : '0;
            if (cset[a]) begin
                if (exp_err == 0) exp_ffa = a;
                exp_err++;
            end
        end
        if (m == 2) begin
            exp_err = 0;
            exp_ffa = 0;
        end
        exp_pass = (m != 2) && (exp_err == 0);

        @(negedge clk);
        base_x  = obs_q.size();
        base_vh = vh_total;
        base_hb = hold_bad;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);

        cyc = 1;
        poked = 1'b0;
        while (!done && cyc < 2000) begin
            if (poke != 0 && !poked && valid && !wr_rd_en) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check("done_seen", 32'(done), 32'd1);
        case (m)
            0:       exp_lat = 2 * DEPTH;
            1:       exp_lat = 2 * DEPTH * (lat + 1);
            2:       exp_lat = TIMEOUT;
            default: exp_lat = cyc - 1;
        endcase
        if (m != 3) check("latency", 32'(cyc - 1), 32'(exp_lat));
        check("pass", 32'(pass), 32'(exp_pass));
        check("timeout", 32'(tmo), 32'(m == 2));
        check("err_count", 32'(err_count), 32'(exp_err));
        check("first_fail_addr", 32'(first_fail_addr), 32'(exp_ffa));
        check("busy_at_done", 32'(busy), 32'd0);
        check("valid_at_done", 32'(valid), 32'd0);
        check("req_hold_stable", 32'(hold_bad - base_hb), 32'd0);

        n = obs_q.size() - base_x;
        if (m == 2) begin
            check("xfer_count", 32'(n), 32'd0);
            check("valid_high_cycles", 32'(vh_total - base_vh), 32'(TIMEOUT));
            check("stuck_request", last_req, 32'({1'b1, AW'(0), SEED}));
        end else begin
            check("xfer_count", 32'(n), 32'(2 * DEPTH));
            for (int i = 0; i < n && i < 2 * DEPTH; i++) begin
                if (i < DEPTH) begin
                    p = SEED ^ 8'(i);
                    e = 32'({1'b1, AW'(i), p});
                end else begin
                    e = 32'({1'b0, AW'(i - DEPTH), 8'h00});
                end
                check("xfer_seq", obs_q[base_x + i], e);
            end
        end

        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
        check("pass_hold", 32'(pass), 32'(exp_pass));
    endtask

    // Reset asserted while address 7 is being written.
    task automatic reset_mid_write();
        int guard;
        mode = 0;
        foreach (cmask[i]) cmask[i] = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(valid && wr_rd_en && addr == AW'(7)) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("reached_addr7", 32'(guard < 100), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [DEPTH-1:0] cs;
        foreach (cmask[i]) cmask[i] = '0;
        foreach (mem[i]) mem[i] = '0;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({busy, done, pass, tmo, valid, wr_rd_en}), 32'd0);
        check("reset_counts", 32'({err_count, first_fail_addr, addr, wdata}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Ideal memory.
        run_test(0, '0, 0);
        check("addr3_written", 32'(w3), 32'h0000_00A6);

        // Slow memory: ready after two waiting cycles.
        lat = 2;
        run_test(1, '0, 0);

        // Corrupted reads at 5 and 9.
        cs = '0;
        cs[5] = 1'b1;
        cs[9] = 1'b1;
        run_test(0, cs, 0);

        // Memory never ready.
        run_test(2, '0, 0);

        // Reset mid-write, then a clean run.
        reset_mid_write();
        run_test(0, '0, 0);

        // Mismatch only on the last address, then a clean rerun with start poked during READ.
        cs = '0;
        cs[DEPTH-1] = 1'b1;
        run_test(0, cs, 0);
        run_test(0, '0, 1);

        // Every address corrupted: count reaches DEPTH.
        run_test(0, '1, 0);

        // Random ready with random corruption sets.
        for (int r = 0; r < 6; r++) begin
            cs = DEPTH'($urandom()) & DEPTH'($urandom());
            run_test(3, cs, r % 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
